// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// pipe_pkg: shared widths, control-field layout and NOP values for the
//           inter-stage pipeline registers.
// Revision: 1.0
// ============================================================================
package pipe_pkg;

    // MEM/WB payload: rdata 32 + alu 32 + rd 5 + pc+4 32
    localparam int MEMWB_DATA_W = 101;
    localparam int MEMWB_CTRL_W = 3;

    localparam int IFID_DATA_W  = 64;
    localparam int IFID_CTRL_W  = 1;
    localparam int IDEX_DATA_W  = 133;
    localparam int IDEX_CTRL_W  = 8;
    localparam int EXMEM_DATA_W = 101;
    localparam int EXMEM_CTRL_W = 5;

    localparam int MEMWB_CTRL_REG_WRITE      = 2;
    localparam int MEMWB_CTRL_MEM_TO_REG_MSB = 1;
    localparam int MEMWB_CTRL_MEM_TO_REG_LSB = 0;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    typedef struct packed {
        logic    reg_write;
        wb_sel_e mem_to_reg;
    } memwb_ctrl_t;

    localparam logic [IFID_CTRL_W-1:0]  IFID_CTRL_NOP  = '0;
    localparam logic [IDEX_CTRL_W-1:0]  IDEX_CTRL_NOP  = '0;
    localparam logic [EXMEM_CTRL_W-1:0] EXMEM_CTRL_NOP = '0;
    localparam logic [MEMWB_CTRL_W-1:0] MEMWB_CTRL_NOP = '0;

endpackage
`default_nettype wire

// File: rtl/pipeline_reg_skid.sv
`default_nettype none
// ============================================================================
// pipeline_reg_skid: valid/ready pipeline stage register with flush, NOP
//                    bubble and optional 2-entry skid buffer.
// Revision: 1.0
// ============================================================================
module pipeline_reg_skid
    import pipe_pkg::*;
#(
    parameter int                 DATA_W   = MEMWB_DATA_W,
    parameter int                 CTRL_W   = MEMWB_CTRL_W,
    parameter logic [CTRL_W-1:0]  CTRL_NOP = {CTRL_W{1'b0}},
    parameter int                 SKID     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [1:0]        count_o
);

    logic              r_main_v;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic              w_con;

    assign w_con       = r_main_v & out_ready_i;
    assign out_valid_o = r_main_v;
    assign out_data_o  = r_main_data;
    // Bubble: a downstream that ignores valid still sees no side effects
    assign out_ctrl_o  = r_main_v ? r_main_ctrl : CTRL_NOP;

    generate
        if (SKID != 0) begin : g_skid
            logic              r_skid_v;
            logic [DATA_W-1:0] r_skid_data;
            logic [CTRL_W-1:0] r_skid_ctrl;
            logic              r_in_ready;
            logic              w_acc;
            logic              w_main_v_nxt;
            logic              w_skid_v_nxt;
            logic              w_main_load_in;
            logic              w_main_load_skid;
            logic              w_skid_load;

            assign w_acc      = in_valid_i & r_in_ready;
            assign in_ready_o = r_in_ready;
            assign count_o    = {r_skid_v, r_main_v & ~r_skid_v};

            always_comb begin
                w_main_v_nxt     = r_main_v;
                w_skid_v_nxt     = r_skid_v;
                w_main_load_in   = 1'b0;
                w_main_load_skid = 1'b0;
                w_skid_load      = 1'b0;
                if (flush_i) begin
                    w_main_v_nxt = 1'b0;
                    w_skid_v_nxt = 1'b0;
                end else begin
                    case ({r_main_v, r_skid_v})
                        2'b00: begin
                            if (w_acc) begin
                                w_main_v_nxt   = 1'b1;
                                w_main_load_in = 1'b1;
                            end
                        end
                        2'b10: begin
                            if (w_acc && w_con) begin
                                w_main_load_in = 1'b1;
                            end else if (w_acc) begin
                                w_skid_v_nxt = 1'b1;
                                w_skid_load  = 1'b1;
                            end else if (w_con) begin
                                w_main_v_nxt = 1'b0;
                            end
                        end
                        2'b11: begin
                            if (w_con) begin
                                w_main_load_skid = 1'b1;
                                w_skid_v_nxt     = 1'b0;
                            end
                        end
                        default: begin
                            w_main_v_nxt = 1'b0;
                            w_skid_v_nxt = 1'b0;
                        end
                    endcase
                end
            end

            // Ready is registered from the next skid state, so it never
            // depends combinationally on out_ready_i.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_main_v    <= 1'b0;
                    r_main_data <= '0;
                    r_main_ctrl <= '0;
                    r_skid_v    <= 1'b0;
                    r_skid_data <= '0;
                    r_skid_ctrl <= '0;
                    r_in_ready  <= 1'b1;
                end else begin
                    r_main_v   <= w_main_v_nxt;
                    r_skid_v   <= w_skid_v_nxt;
                    r_in_ready <= ~w_skid_v_nxt;
                    if (w_main_load_in) begin
                        r_main_data <= in_data_i;
                        r_main_ctrl <= in_ctrl_i;
                    end else if (w_main_load_skid) begin
                        r_main_data <= r_skid_data;
                        r_main_ctrl <= r_skid_ctrl;
                    end
                    if (w_skid_load) begin
                        r_skid_data <= in_data_i;
                        r_skid_ctrl <= in_ctrl_i;
                    end
                end
            end
        end else begin : g_noskid
            logic w_acc;

            assign in_ready_o = ~r_main_v | out_ready_i;
            assign w_acc      = in_valid_i & in_ready_o;
            assign count_o    = {1'b0, r_main_v};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_main_v    <= 1'b0;
                    r_main_data <= '0;
                    r_main_ctrl <= '0;
                end else if (flush_i) begin
                    r_main_v <= 1'b0;
                end else if (w_acc) begin
                    r_main_v    <= 1'b1;
                    r_main_data <= in_data_i;
                    r_main_ctrl <= in_ctrl_i;
                end else if (w_con) begin
                    r_main_v <= 1'b0;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipeline_reg_skid.sv
`default_nettype none
// ============================================================================
// tb_pipeline_reg_skid: scoreboard bench for the SKID=1 and SKID=0 builds.
// Revision: 1.0
// ============================================================================
module tb_pipeline_reg_skid;

    localparam int DW = 101;
    localparam int CW = 3;
    localparam logic [CW-1:0] NOP = 3'b000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic          flush1 = 0, v1 = 0, or1 = 0;
    logic [DW-1:0] d1 = '0;
    logic [CW-1:0] c1 = '0;
    logic          ir1, ov1;
    logic [DW-1:0] od1;
    logic [CW-1:0] oc1;
    logic [1:0]    cnt1;

    logic          flush0 = 0, v0 = 0, or0 = 0;
    logic [DW-1:0] d0 = '0;
    logic [CW-1:0] c0 = '0;
    logic          ir0, ov0;
    logic [DW-1:0] od0;
    logic [CW-1:0] oc0;
    logic [1:0]    cnt0;

    int n_checks = 0;
    int n_errors = 0;

    logic [CW+DW-1:0] q1[$];
    logic [CW+DW-1:0] q0[$];

    always #5 clk = ~clk;

    pipeline_reg_skid #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP), .SKID(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush1),
        .in_valid_i(v1), .in_ready_o(ir1), .in_data_i(d1), .in_ctrl_i(c1),
        .out_valid_o(ov1), .out_ready_i(or1), .out_data_o(od1), .out_ctrl_o(oc1),
        .count_o(cnt1)
    );

    pipeline_reg_skid #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP), .SKID(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush0),
        .in_valid_i(v0), .in_ready_o(ir0), .in_data_i(d0), .in_ctrl_i(c0),
        .out_valid_o(ov0), .out_ready_i(or0), .out_data_o(od0), .out_ctrl_o(oc0),
        .count_o(cnt0)
    );

    // Output monitors: a valid output must equal the scoreboard head, held
    // while stalled and popped when consumed; an invalid one must show NOP.
    always @(negedge clk) begin
        n_checks++;
        if (ov1) begin
            if (q1.size() == 0) begin
                n_errors++;
                $display("FAIL mon1_unexpected: got %h, scoreboard empty", {oc1, od1});
            end else begin
                if ({oc1, od1} !== q1[0]) begin
                    n_errors++;
                    $display("FAIL mon1_data: got %h, expected %h", {oc1, od1}, q1[0]);
                end
                if (or1) void'(q1.pop_front());
            end
        end else if (oc1 !== NOP) begin
            n_errors++;
            $display("FAIL mon1_bubble: ctrl %b, expected %b", oc1, NOP);
        end
    end

    always @(negedge clk) begin
        n_checks++;
        if (ov0) begin
            if (q0.size() == 0) begin
                n_errors++;
                $display("FAIL mon0_unexpected: got %h, scoreboard empty", {oc0, od0});
            end else begin
                if ({oc0, od0} !== q0[0]) begin
                    n_errors++;
                    $display("FAIL mon0_data: got %h, expected %h", {oc0, od0}, q0[0]);
                end
                if (or0) void'(q0.pop_front());
            end
        end else if (oc0 !== NOP) begin
            n_errors++;
            $display("FAIL mon0_bubble: ctrl %b, expected %b", oc0, NOP);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({ov1, oc1, ir1, cnt1} !== {1'b0, NOP, 1'b1, 2'd0} || od1 !== '0) begin
            n_errors++;
            $display("FAIL reset_skid1: v=%b c=%b r=%b n=%0d d=%h, expected v=0 c=000 r=1 n=0 d=0",
                     ov1, oc1, ir1, cnt1, od1);
        end
        n_checks++;
        if ({ov0, oc0, ir0, cnt0} !== {1'b0, NOP, 1'b1, 2'd0} || od0 !== '0) begin
            n_errors++;
            $display("FAIL reset_skid0: v=%b c=%b r=%b n=%0d d=%h, expected v=0 c=000 r=1 n=0 d=0",
                     ov0, oc0, ir0, cnt0, od0);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_stream();
        or1 = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            v1 = 1'b1; d1 = DW'(i); c1 = 3'b011;
            n_checks++;
            if (ir1 !== 1'b1) begin
                n_errors++;
                $display("FAIL stream_ready%0d: got %b, expected 1", i, ir1);
            end
            q1.push_back({c1, d1});
            step();
            n_checks++;
            if (ov1 !== 1'b1 || od1 !== DW'(i) || oc1 !== 3'b011) begin
                n_errors++;
                $display("FAIL stream_latency%0d: v=%b d=%h c=%b, expected v=1 d=%0d c=011",
                         i, ov1, od1, oc1, i);
            end
        end
        v1 = 1'b0;
        step();
        n_checks++;
        if (ov1 !== 1'b0 || cnt1 !== 2'd0) begin
            n_errors++;
            $display("FAIL stream_drain: v=%b n=%0d, expected v=0 n=0", ov1, cnt1);
        end
    endtask

    task automatic test_backpressure();
        or1 = 1'b0;
        v1 = 1'b1; d1 = 'hAA; c1 = 3'b101;
        q1.push_back({c1, d1});
        step();
        d1 = 'hBB; c1 = 3'b110;
        n_checks++;
        if (ir1 !== 1'b1 || cnt1 !== 2'd1) begin
            n_errors++;
            $display("FAIL bp_full1: r=%b n=%0d, expected r=1 n=1", ir1, cnt1);
        end
        q1.push_back({c1, d1});
        step();
        d1 = 'hCC; c1 = 3'b001;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (ir1 !== 1'b0 || cnt1 !== 2'd2 || od1 !== DW'('hAA)) begin
                n_errors++;
                $display("FAIL bp_full2_%0d: r=%b n=%0d d=%h, expected r=0 n=2 d=aa", i, ir1, cnt1, od1);
            end
            if (i == 0) step();
        end
        or1 = 1'b1;
        step();
        n_checks++;
        if (ov1 !== 1'b1 || od1 !== DW'('hBB) || ir1 !== 1'b1 || cnt1 !== 2'd1) begin
            n_errors++;
            $display("FAIL bp_release: v=%b d=%h r=%b n=%0d, expected v=1 d=bb r=1 n=1",
                     ov1, od1, ir1, cnt1);
        end
        q1.push_back({c1, d1});
        step();
        v1 = 1'b0;
        n_checks++;
        if (od1 !== DW'('hCC)) begin
            n_errors++;
            $display("FAIL bp_third: d=%h, expected cc", od1);
        end
        step();
    endtask

    task automatic test_flush();
        or1 = 1'b0;
        v1 = 1'b1; d1 = 'h11; c1 = 3'b111;
        q1.push_back({c1, d1});
        step();
        d1 = 'h22;
        q1.push_back({c1, d1});
        step();
        flush1 = 1'b1; d1 = 'h33;
        step();
        q1.delete();
        flush1 = 1'b0; v1 = 1'b0;
        n_checks++;
        if (ov1 !== 1'b0 || oc1 !== NOP || cnt1 !== 2'd0 || ir1 !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_full2: v=%b c=%b n=%0d r=%b, expected v=0 c=000 n=0 r=1",
                     ov1, oc1, cnt1, ir1);
        end
        v1 = 1'b1; d1 = 'h44;
        q1.push_back({c1, d1});
        step();
        flush1 = 1'b1; d1 = 'h99;
        n_checks++;
        if (ir1 !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_ready: got %b, expected 1", ir1);
        end
        step();
        q1.delete();
        flush1 = 1'b0; v1 = 1'b0; or1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (ov1 !== 1'b0 || cnt1 !== 2'd0) begin
                n_errors++;
                $display("FAIL flush_discard%0d: v=%b n=%0d, expected v=0 n=0", i, ov1, cnt1);
            end
            step();
        end
    endtask

    task automatic test_noskid();
        or0 = 1'b0;
        v0 = 1'b1; d0 = 'h5A; c0 = 3'b011;
        n_checks++;
        if (ir0 !== 1'b1) begin
            n_errors++;
            $display("FAIL ns_empty_ready: got %b, expected 1", ir0);
        end
        q0.push_back({c0, d0});
        step();
        d0 = 'h6B; c0 = 3'b110;
        n_checks++;
        if (ir0 !== 1'b0 || cnt0 !== 2'd1) begin
            n_errors++;
            $display("FAIL ns_stall_ready: r=%b n=%0d, expected r=0 n=1", ir0, cnt0);
        end
        step();
        or0 = 1'b1;
        #1;
        n_checks++;
        if (ir0 !== 1'b1) begin
            n_errors++;
            $display("FAIL ns_comb_ready: got %b, expected 1", ir0);
        end
        q0.push_back({c0, d0});
        step();
        v0 = 1'b0;
        n_checks++;
        if (ov0 !== 1'b1 || od0 !== DW'('h6B) || cnt0 !== 2'd1) begin
            n_errors++;
            $display("FAIL ns_replace: v=%b d=%h n=%0d, expected v=1 d=6b n=1", ov0, od0, cnt0);
        end
        step();
        n_checks++;
        if (ov0 !== 1'b0 || cnt0 !== 2'd0) begin
            n_errors++;
            $display("FAIL ns_drain: v=%b n=%0d, expected v=0 n=0", ov0, cnt0);
        end
    endtask

    task automatic test_async_reset();
        or1 = 1'b0;
        v1 = 1'b1; d1 = 'h77; c1 = 3'b010;
        q1.push_back({c1, d1});
        step();
        d1 = 'h88;
        q1.push_back({c1, d1});
        step();
        v1 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ov1 !== 1'b0 || cnt1 !== 2'd0 || ir1 !== 1'b1) begin
            n_errors++;
            $display("FAIL areset_async: v=%b n=%0d r=%b, expected v=0 n=0 r=1", ov1, cnt1, ir1);
        end
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        v1 = 1'b1; d1 = 'h55; c1 = 3'b011;
        n_checks++;
        if (ir1 !== 1'b1) begin
            n_errors++;
            $display("FAIL areset_ready: got %b, expected 1", ir1);
        end
        q1.push_back({c1, d1});
        step();
        v1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (ov1 !== 1'b1 || od1 !== DW'('h55) || cnt1 !== 2'd1) begin
                n_errors++;
                $display("FAIL areset_first%0d: v=%b d=%h n=%0d, expected v=1 d=55 n=1",
                         i, ov1, od1, cnt1);
            end
            step();
        end
        or1 = 1'b1;
        repeat (2) step();
        n_checks++;
        if (cnt1 !== 2'd0) begin
            n_errors++;
            $display("FAIL areset_drain: n=%0d, expected 0", cnt1);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_noskid();
        test_async_reset();
        n_checks++;
        if (q1.size() != 0 || q0.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_empty: pending %0d/%0d, expected 0/0", q1.size(), q0.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
